lfsr_prng_gen: RTL and testbench

Parametrised Galois-LFSR pseudo-random word generator. It replaces the fixed 32-bit generator with configurable width, polynomial, default seed and steps-per-word, plus a reloadable seed, a zero-seed guard, a valid/ready output handshake with hold-on-stall, and a delivered-word counter. It feeds stimulus generators, dither and scrambler blocks that consume one word per accepted handshake.

---
 rtl/lfsr_prng_gen.sv | 90 +++++++++
 tb/tb_lfsr_prng_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_gen.sv
// Galois-LFSR pseudo-random word generator with a reloadable seed, a zero-seed guard,
// a valid/ready output that holds on stall, and a counter of accepted words.
module lfsr_prng_gen #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   TAPS         = 32'h8020_0003,
  parameter logic [WIDTH-1:0]   DEFAULT_SEED = 32'h0000_0001,
  parameter int unsigned        STEPS        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_data,
  output logic             seed_zero_err,
  output logic [31:0]      word_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rand_data_q, rand_data_d;
  logic             rand_valid_q, rand_valid_d;
  logic             seed_zero_err_q, seed_zero_err_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] next_state;
  logic             load;
  logic             accept;

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      t = t[0] ? ((t >> 1) ^ TAPS) : (t >> 1);
    end
    return t;
  endfunction

  always_comb begin
    next_state      = adv(state_q);
    load            = enable && (!rand_valid_q || rand_ready) && !seed_load;
    accept          = rand_valid_q && rand_ready;
    state_d         = state_q;
    rand_data_d     = rand_data_q;
    rand_valid_d    = rand_valid_q;
    seed_zero_err_d = 1'b0;
    word_cnt_d      = word_cnt_q;

    if (seed_load) begin
      // A word handed over in the same cycle as a reload is dropped, not counted.
      state_d         = (seed == '0) ? DEFAULT_SEED : seed;
      seed_zero_err_d = (seed == '0);
      rand_valid_d    = 1'b0;
      word_cnt_d      = '0;
    end else begin
      if (load) begin
        state_d      = next_state;
        rand_data_d  = next_state;
        rand_valid_d = 1'b1;
      end else if (accept) begin
        rand_valid_d = 1'b0;
      end
      if (accept) begin
        word_cnt_d = word_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= DEFAULT_SEED;
      rand_data_q     <= '0;
      rand_valid_q    <= 1'b0;
      seed_zero_err_q <= 1'b0;
      word_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      rand_data_q     <= rand_data_d;
      rand_valid_q    <= rand_valid_d;
      seed_zero_err_q <= seed_zero_err_d;
      word_cnt_q      <= word_cnt_d;
    end
  end

  assign rand_valid    = rand_valid_q;
  assign rand_data     = rand_data_q;
  assign seed_zero_err = seed_zero_err_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed bench for lfsr_prng_gen: default, STEPS=2 and 8-bit instances share one stimulus.
module tb_lfsr_prng_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic        enable;
  logic        rand_ready;

  logic        v1, v2, v8;
  logic [31:0] d1, d2;
  logic [7:0]  d8;
  logic        e1, e2, e8;
  logic [31:0] c1, c2, c8;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  lfsr_prng_gen #(.WIDTH(32), .TAPS(32'h8020_0003), .DEFAULT_SEED(32'h1), .STEPS(1)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .rand_ready(rand_ready), .rand_valid(v1), .rand_data(d1), .seed_zero_err(e1), .word_cnt(c1));

  lfsr_prng_gen #(.WIDTH(32), .TAPS(32'h8020_0003), .DEFAULT_SEED(32'h1), .STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .rand_ready(rand_ready), .rand_valid(v2), .rand_data(d2), .seed_zero_err(e2), .word_cnt(c2));

  lfsr_prng_gen #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .STEPS(1)) dut8 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed[7:0]), .enable(enable),
    .rand_ready(rand_ready), .rand_valid(v8), .rand_data(d8), .seed_zero_err(e8), .word_cnt(c8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = '0; enable = 1'b0; rand_ready = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, v1}, 32'd0);
    check("rst_data", d1, 32'd0);
    check("rst_err", {31'd0, e1}, 32'd0);
    check("rst_cnt", c1, 32'd0);

    // default sequence and STEPS=2 sequence
    rst = 1'b0; enable = 1'b1; rand_ready = 1'b1;
    tick();
    check("seq0_valid", {31'd0, v1}, 32'd1);
    check("seq0", d1, 32'h8020_0003);
    check("seq0_cnt", c1, 32'd0);
    check("s2_seq0", d2, 32'hC030_0002);
    tick();
    check("seq1", d1, 32'hC030_0002);
    check("seq1_cnt", c1, 32'd1);
    check("s2_seq1", d2, 32'hB02C_0003);
    check("s2_valid", {31'd0, v2}, 32'd1);
    tick();
    check("seq2", d1, 32'h6018_0001);
    tick();
    check("seq3", d1, 32'hB02C_0003);
    check("seq3_cnt", c1, 32'd3);
    enable = 1'b0;
    tick();
    check("drain_valid", {31'd0, v1}, 32'd0);
    check("drain_cnt", c1, 32'd4);

    // stall holds data and count
    rst = 1'b1; tick();
    rst = 1'b0; enable = 1'b1; rand_ready = 1'b1;
    tick(); tick();
    check("pre_stall", d1, 32'hC030_0002);
    rand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", d1, 32'hC030_0002);
      check("stall_cnt", c1, 32'd1);
      check("stall_valid", {31'd0, v1}, 32'd1);
    end
    rand_ready = 1'b1;
    tick();
    check("post_stall", d1, 32'h6018_0001);
    check("post_stall_cnt", c1, 32'd2);

    // reset during stall
    rand_ready = 1'b0;
    tick();
    rst = 1'b1; tick();
    check("rst_stall_valid", {31'd0, v1}, 32'd0);
    check("rst_stall_cnt", c1, 32'd0);
    rst = 1'b0; rand_ready = 1'b1;
    tick();
    check("restart", d1, 32'h8020_0003);

    // zero seed guard
    seed_load = 1'b1; seed = 32'h0;
    tick();
    check("zs_err", {31'd0, e1}, 32'd1);
    check("zs_valid", {31'd0, v1}, 32'd0);
    check("zs_cnt", c1, 32'd0);
    seed_load = 1'b0;
    tick();
    check("zs_err_clr", {31'd0, e1}, 32'd0);
    check("zs_data", d1, 32'h8020_0003);
    check("zs_s2_data", d2, 32'hC030_0002);

    // reload mid-stream after 3 words
    tick(); tick();
    check("mid_word3", d1, 32'h6018_0001);
    seed_load = 1'b1; seed = 32'h2;
    tick();
    check("reload_valid", {31'd0, v1}, 32'd0);
    check("reload_cnt", c1, 32'd0);
    check("reload_err", {31'd0, e1}, 32'd0);
    seed_load = 1'b0;
    tick();
    check("reload_data", d1, 32'h0000_0001);
    check("reload_v", {31'd0, v1}, 32'd1);
    tick();
    check("reload_next", d1, 32'h8020_0003);
    check("reload_next_cnt", c1, 32'd1);

    // enable low: pending word stays until accepted
    enable = 1'b0; rand_ready = 1'b0;
    tick();
    check("en0_hold_v", {31'd0, v1}, 32'd1);
    check("en0_hold_d", d1, 32'h8020_0003);
    rand_ready = 1'b1;
    tick();
    check("en0_accept_v", {31'd0, v1}, 32'd0);
    check("en0_accept_cnt", c1, 32'd2);

    // counter wrap
    enable = 1'b1;
    tick();
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt_q;
    tick();
    check("wrap_max", c1, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", c1, 32'd0);

    // 8-bit period: seed 1 must first reappear as word 255
    rst = 1'b1; tick();
    rst = 1'b0; enable = 1'b1; rand_ready = 1'b1;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (v8 && d8 == 8'h01) begin
        n = i;
        break;
      end
    end
    check("period8", n, 32'd255);
    check("first8_after_restart", {24'd0, d8}, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
